port_scheduler: RTL and testbench

Per-output-port packet scheduler for the 16-port shared-SRAM switch. One instance sits behind each output port. Each instance picks one of `NUM_PRIO` priority queues whose head packet is complete, using either strict priority (SP) or weighted round robin (WRR). It then issues one SRAM read request per beat for that packet and emits `rd_sop`/`rd_vld`/`rd_eop`, delayed to line up with the SRAM read data. It generalises the read-arbiter function with configurable queue count, weight width, packet length width and SRAM read latency, and adds per-queue credit-based WRR with stall-aware beat counting.

---
 rtl/port_scheduler_pkg.sv | 16 +
 rtl/port_scheduler_rr_pick.sv | 33 +++
 rtl/port_scheduler.sv | 151 +++++++++++++++
 tb/tb_port_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_scheduler_pkg.sv
// Shared types and default constants for the per-output-port scheduler.
// Imported by the scheduler top and its circular picker.
package port_scheduler_pkg;
  localparam int DEF_NUM_PRIO = 8;
  localparam int DEF_LEN_W    = 7;
  localparam int DEF_WEIGHT_W = 4;

  localparam logic SP  = 1'b0;
  localparam logic WRR = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RELOAD = 2'd1,
    XFER   = 2'd2
  } state_t;
endpackage

// File: rtl/port_scheduler_rr_pick.sv
// Combinational circular first-one finder: returns the first set request at or after ptr.
// Strict priority uses it with ptr tied to zero.
module rr_pick
  import port_scheduler_pkg::*;
#(
  parameter int NUM_PRIO = DEF_NUM_PRIO,
  parameter int PRIO_W   = $clog2(NUM_PRIO)
) (
  input  logic [NUM_PRIO-1:0] req,
  input  logic [PRIO_W-1:0]   ptr,
  output logic [PRIO_W-1:0]   grant_idx,
  output logic                found
);
  logic [PRIO_W-1:0] idx_at [NUM_PRIO];

  generate
    for (genvar gi = 0; gi < NUM_PRIO; gi++) begin : g_rot
      assign idx_at[gi] = PRIO_W'((32'(ptr) + gi) % NUM_PRIO);
    end
  endgenerate

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int off = NUM_PRIO - 1; off >= 0; off--) begin
      if (req[idx_at[off]]) begin
        grant_idx = idx_at[off];
        found     = 1'b1;
      end
    end
  end
endmodule

// File: rtl/port_scheduler.sv
// Output-port packet scheduler: SP or credit-based WRR queue selection, one SRAM
// read strobe per beat, and framing delayed by RD_LAT to line up with read data.
module port_scheduler
  import port_scheduler_pkg::*;
#(
  parameter int NUM_PRIO = DEF_NUM_PRIO,
  parameter int PRIO_W   = 3,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int RD_LAT   = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sp0_wrr1,
  input  logic [NUM_PRIO*WEIGHT_W-1:0] wrr_weight,
  input  logic [NUM_PRIO-1:0]          prepared,
  input  logic [NUM_PRIO*LEN_W-1:0]    head_len,
  input  logic [NUM_PRIO-1:0]          ready,
  output logic [NUM_PRIO-1:0]          deq,
  output logic                         rd_req,
  output logic [PRIO_W-1:0]            rd_prio,
  output logic                         busy,
  output logic                         rd_sop,
  output logic                         rd_eop,
  output logic                         rd_vld
);
  state_t                state_reg, state_next;
  logic [WEIGHT_W-1:0]   credit_reg [NUM_PRIO];
  logic [PRIO_W-1:0]     rr_ptr_reg;
  logic [PRIO_W-1:0]     prio_reg;
  logic [LEN_W-1:0]      beat_cnt_reg;
  logic                  prev_mode_reg;
  logic                  started_reg;
  logic [NUM_PRIO-1:0]   deq_reg;
  logic [2:0]            pipe_reg [RD_LAT];

  logic [NUM_PRIO-1:0]   eligible, has_credit, weighted, pick_req;
  logic [PRIO_W-1:0]     pick_ptr, pick_idx;
  logic                  pick_found, need_reload, grant;
  logic                  first_beat, last_beat;
  logic [LEN_W-1:0]      sel_len;

  assign eligible = prepared & ready;

  generate
    for (genvar gi = 0; gi < NUM_PRIO; gi++) begin : g_q
      assign has_credit[gi] = (credit_reg[gi] != '0);
      assign weighted[gi]   = |wrr_weight[gi*WEIGHT_W +: WEIGHT_W];

      always_ff @(posedge clk) begin
        if (rst) begin
          credit_reg[gi] <= '0;
        end else if (state_reg == RELOAD) begin
          credit_reg[gi] <= wrr_weight[gi*WEIGHT_W +: WEIGHT_W];
        end else if (grant && sp0_wrr1 == WRR && pick_idx == PRIO_W'(gi)) begin
          credit_reg[gi] <= credit_reg[gi] - 1'b1;
        end
      end
    end
  endgenerate

  assign pick_req = (sp0_wrr1 == WRR) ? (eligible & has_credit) : eligible;
  assign pick_ptr = (sp0_wrr1 == WRR) ? rr_ptr_reg : '0;

  rr_pick #(
    .NUM_PRIO (NUM_PRIO),
    .PRIO_W   (PRIO_W)
  ) u_pick (
    .req       (pick_req),
    .ptr       (pick_ptr),
    .grant_idx (pick_idx),
    .found     (pick_found)
  );

  // Entering WRR from SP always refreshes credits; otherwise reload only when an
  // eligible queue could actually be served by a refill (weight 0 never loops).
  assign need_reload = (sp0_wrr1 == WRR) &&
                       ((prev_mode_reg == SP) || (!pick_found && |(eligible & weighted)));
  assign grant       = (state_reg == IDLE) && !need_reload && pick_found;
  assign sel_len     = head_len[pick_idx*LEN_W +: LEN_W];

  assign rd_req     = (state_reg == XFER) && ready[prio_reg];
  assign first_beat = rd_req && !started_reg;
  assign last_beat  = rd_req && (beat_cnt_reg == LEN_W'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (need_reload)  state_next = RELOAD;
        else if (grant)   state_next = XFER;
      end
      RELOAD:             state_next = IDLE;
      XFER: begin
        if (last_beat)    state_next = IDLE;
      end
      default:            state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      prio_reg      <= '0;
      beat_cnt_reg  <= '0;
      prev_mode_reg <= SP;
      started_reg   <= 1'b0;
      deq_reg       <= '0;
    end else begin
      state_reg <= state_next;
      deq_reg   <= '0;
      if (state_reg == IDLE) prev_mode_reg <= sp0_wrr1;
      if (grant) begin
        deq_reg      <= NUM_PRIO'(1) << pick_idx;
        prio_reg     <= pick_idx;
        beat_cnt_reg <= (sel_len == '0) ? LEN_W'(1) : sel_len;
        started_reg  <= 1'b0;
        if (sp0_wrr1 == WRR && credit_reg[pick_idx] == WEIGHT_W'(1)) begin
          rr_ptr_reg <= (pick_idx == PRIO_W'(NUM_PRIO - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      if (rd_req) begin
        beat_cnt_reg <= beat_cnt_reg - 1'b1;
        started_reg  <= 1'b1;
      end
    end
  end

  // Framing delay line matching the SRAM read latency.
  generate
    for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_pipe
      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_reg[gi] <= '0;
        end else if (gi == 0) begin
          pipe_reg[gi] <= {rd_req, first_beat, last_beat};
        end else begin
          pipe_reg[gi] <= pipe_reg[(gi == 0) ? 0 : gi-1];
        end
      end
    end
  endgenerate

  assign rd_vld  = pipe_reg[RD_LAT-1][2];
  assign rd_sop  = pipe_reg[RD_LAT-1][1];
  assign rd_eop  = pipe_reg[RD_LAT-1][0];
  assign deq     = deq_reg;
  assign rd_prio = prio_reg;
  assign busy    = (state_reg == XFER);
endmodule

// File: tb/tb_port_scheduler.sv
// Bench for port_scheduler: directed scenarios plus random traffic, checked every
// cycle against a transaction-level scheduling model.
module tb_port_scheduler;
  localparam int NP = 8;
  localparam int PW = 3;
  localparam int WW = 4;
  localparam int LW = 7;
  localparam int RL = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sp0_wrr1 = 1'b0;
  logic [NP*WW-1:0] wrr_weight = '0;
  logic [NP-1:0]   prepared = '0;
  logic [NP*LW-1:0] head_len = '0;
  logic [NP-1:0]   ready = '1;
  logic [NP-1:0]   deq;
  logic            rd_req, busy, rd_sop, rd_eop, rd_vld;
  logic [PW-1:0]   rd_prio;

  port_scheduler #(.NUM_PRIO(NP), .PRIO_W(PW), .WEIGHT_W(WW), .LEN_W(LW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .sp0_wrr1(sp0_wrr1), .wrr_weight(wrr_weight),
    .prepared(prepared), .head_len(head_len), .ready(ready), .deq(deq),
    .rd_req(rd_req), .rd_prio(rd_prio), .busy(busy), .rd_sop(rd_sop),
    .rd_eop(rd_eop), .rd_vld(rd_vld)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  function automatic void chk(string nm, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", nm, act, req, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int        m_phase = 0;            // 0 waiting, 1 refilling credits, 2 moving a packet
  int        m_credit [NP];
  int        m_ptr = 0, m_prio = 0, m_left = 0;
  bit        m_started = 0, m_prev = 0;
  bit [NP-1:0] m_deq = '0;
  bit [2:0]  hist [$];

  // observation stats (cleared by the stimulus)
  int cyc = 0, n_req = 0, n_vld = 0, n_sop = 0, n_eop = 0, n_se = 0, n_stall = 0, n_busy = 0;
  bit [NP-1:0] deq_log [$];
  int          deq_cyc [$];

  initial for (int i = 0; i < NP; i++) m_credit[i] = 0;

  always @(negedge clk) begin
    bit exp_req, exp_first, exp_last, mode, go_reload;
    bit [2:0] exp_pipe;
    bit [NP-1:0] elig;
    int g, q, len;

    exp_req   = (m_phase == 2) && ready[m_prio];
    exp_first = exp_req && !m_started;
    exp_last  = exp_req && (m_left == 1);
    exp_pipe  = (hist.size() == RL) ? hist[0] : 3'b000;

    chk("deq", deq, m_deq);
    chk("busy", busy, m_phase == 2);
    chk("rd_req", rd_req, exp_req);
    chk("rd_vld", rd_vld, exp_pipe[2]);
    chk("rd_sop", rd_sop, exp_pipe[1]);
    chk("rd_eop", rd_eop, exp_pipe[0]);
    if (m_phase == 2) chk("rd_prio", rd_prio, m_prio);

    if (rd_req) n_req++;
    if (rd_vld) n_vld++;
    if (rd_sop) n_sop++;
    if (rd_eop) n_eop++;
    if (rd_sop && rd_eop) n_se++;
    if (busy && !rd_req) n_stall++;
    if (busy) n_busy++;
    if (deq != '0) begin deq_log.push_back(deq); deq_cyc.push_back(cyc); end
    cyc++;

    if (hist.size() == RL) void'(hist.pop_front());
    hist.push_back({exp_req, exp_first, exp_last});

    if (rst) begin
      m_phase = 0; m_ptr = 0; m_prio = 0; m_left = 0; m_started = 0; m_prev = 0; m_deq = '0;
      for (int i = 0; i < NP; i++) m_credit[i] = 0;
      hist.delete();
    end else begin
      m_deq = '0;
      case (m_phase)
        2: if (exp_req) begin
             m_left--; m_started = 1;
             if (m_left == 0) m_phase = 0;
           end
        1: begin
             for (int i = 0; i < NP; i++) m_credit[i] = wrr_weight[i*WW +: WW];
             m_phase = 0;
           end
        default: begin
          mode = sp0_wrr1; elig = prepared & ready; g = -1; go_reload = 0;
          if (mode && !m_prev) go_reload = 1;
          else if (!mode) begin
            for (int i = NP-1; i >= 0; i--) if (elig[i]) g = i;
          end else begin
            for (int k = NP-1; k >= 0; k--) begin
              q = (m_ptr + k) % NP;
              if (elig[q] && m_credit[q] > 0) g = q;
            end
            if (g < 0)
              for (int i = 0; i < NP; i++)
                if (elig[i] && wrr_weight[i*WW +: WW] != 0) go_reload = 1;
          end
          if (go_reload) m_phase = 1;
          else if (g >= 0) begin
            m_deq[g] = 1'b1; m_prio = g; m_started = 0;
            len = head_len[g*LW +: LW];
            m_left = (len == 0) ? 1 : len;
            if (mode) begin
              m_credit[g]--;
              if (m_credit[g] == 0) m_ptr = (g + 1) % NP;
            end
            m_phase = 2;
          end
          m_prev = mode;
        end
      endcase
    end
  end

  // ---------------- stimulus environment ----------------
  int pkt_cnt [NP];
  bit rand_len = 0;

  function automatic void apply_prep();
    for (int i = 0; i < NP; i++) prepared[i] = (pkt_cnt[i] > 0);
  endfunction

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) begin
      if (deq[i]) begin
        if (pkt_cnt[i] > 0) pkt_cnt[i]--;
        if (rand_len) head_len[i*LW +: LW] = LW'($urandom_range(0, 6));
      end
    end
    apply_prep();
  endtask

  task automatic clr_stats();
    n_req = 0; n_vld = 0; n_sop = 0; n_eop = 0; n_se = 0; n_stall = 0; n_busy = 0;
    deq_log.delete(); deq_cyc.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NP; i++) pkt_cnt[i] = 0;
    apply_prep();
    rst = 1'b1; step(); step(); rst = 1'b0;
    clr_stats();
  endtask

  task automatic run_until_idle(input int maxc);
    bit done;
    done = 0;
    for (int c = 0; c < maxc && !done; c++) begin
      step();
      if (!busy && prepared == '0) done = 1;
    end
    if (!done) chk("timeout", 0, 1);
    for (int c = 0; c < RL + 2; c++) step();
  endtask

  initial begin
    int t0;
    step(); step();
    chk("rst_outputs", {deq, rd_req, rd_prio, busy, rd_sop, rd_eop, rd_vld}, 0);
    rst = 1'b0;

    // strict priority: queue 1 (3 beats) then queue 3 (2 beats)
    do_reset();
    sp0_wrr1 = 1'b0; ready = '1;
    head_len[1*LW +: LW] = 3; head_len[3*LW +: LW] = 2;
    pkt_cnt[1] = 1; pkt_cnt[3] = 1; apply_prep();
    t0 = cyc;
    run_until_idle(60);
    chk("sp_ndeq", deq_log.size(), 2);
    if (deq_log.size() == 2) begin
      chk("sp_deq0", deq_log[0], 8'h02);
      chk("sp_deq1", deq_log[1], 8'h08);
      chk("sp_deq_lat", deq_cyc[0] - t0, 1);
    end
    chk("sp_vld", n_vld, 5);
    chk("sp_sop", n_sop, 2);
    chk("sp_eop", n_eop, 2);

    // WRR weights q0=2 q1=1, single-beat packets
    do_reset();
    sp0_wrr1 = 1'b1; wrr_weight = '0;
    wrr_weight[0 +: WW] = 2; wrr_weight[WW +: WW] = 1;
    head_len[0 +: LW] = 1; head_len[LW +: LW] = 1;
    pkt_cnt[0] = 4; pkt_cnt[1] = 2; apply_prep();
    run_until_idle(100);
    chk("wrr_ndeq", deq_log.size(), 6);
    if (deq_log.size() == 6) begin
      chk("wrr_o0", deq_log[0], 8'h01); chk("wrr_o1", deq_log[1], 8'h01);
      chk("wrr_o2", deq_log[2], 8'h02); chk("wrr_o3", deq_log[3], 8'h01);
      chk("wrr_o4", deq_log[4], 8'h01); chk("wrr_o5", deq_log[5], 8'h02);
    end

    // stall: 4-beat packet on queue 2, ready[2] low 3 cycles after beat 2
    do_reset();
    sp0_wrr1 = 1'b0; ready = '1;
    head_len[2*LW +: LW] = 4; pkt_cnt[2] = 1; apply_prep();
    for (int c = 0; c < 20 && n_req < 2; c++) step();
    chk("stall_beats_seen", n_req, 2);
    ready[2] = 1'b0; step(); step(); step(); ready[2] = 1'b1;
    run_until_idle(40);
    chk("stall_vld", n_vld, 4);
    chk("stall_sop", n_sop, 1);
    chk("stall_eop", n_eop, 1);
    chk("stall_cycles", n_stall, 3);

    // zero length is a single beat
    do_reset();
    head_len[5*LW +: LW] = 0; pkt_cnt[5] = 1; apply_prep();
    run_until_idle(30);
    chk("len0_vld", n_vld, 1);
    chk("len0_sop_eop", n_se, 1);

    // WRR with every eligible queue at weight 0
    do_reset();
    sp0_wrr1 = 1'b1; wrr_weight = '0;
    pkt_cnt[0] = 1; pkt_cnt[4] = 1; apply_prep();
    for (int c = 0; c < 20; c++) step();
    chk("w0_busy", n_busy, 0);
    chk("w0_ndeq", deq_log.size(), 0);

    // reset on the 2nd beat of a 5-beat packet
    do_reset();
    sp0_wrr1 = 1'b0;
    head_len[6*LW +: LW] = 5; pkt_cnt[6] = 1; apply_prep();
    for (int c = 0; c < 20 && n_req < 1; c++) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("mid_rst_outputs", {deq, rd_req, busy, rd_sop, rd_eop, rd_vld}, 0);
    clr_stats();
    for (int c = 0; c < 10; c++) step();
    chk("mid_rst_no_vld", n_vld, 0);
    pkt_cnt[6] = 1; apply_prep();
    run_until_idle(40);
    chk("mid_rst_regrant", deq_log.size(), 1);
    chk("mid_rst_vld", n_vld, 5);

    // SP -> WRR switch while idle: one reload bubble, then grant from queue 0
    clr_stats();
    wrr_weight = '0; wrr_weight[0 +: WW] = 1; wrr_weight[3*WW +: WW] = 1;
    head_len[0 +: LW] = 1; head_len[3*LW +: LW] = 1;
    pkt_cnt[0] = 2; pkt_cnt[3] = 2; apply_prep(); sp0_wrr1 = 1'b1;
    t0 = cyc;
    run_until_idle(60);
    chk("sw_ndeq", deq_log.size(), 4);
    if (deq_log.size() == 4) begin
      chk("sw_first", deq_log[0], 8'h01);
      chk("sw_second", deq_log[1], 8'h08);
      chk("sw_lat", deq_cyc[0] - t0, 3);
    end

    // random traffic
    do_reset();
    rand_len = 1;
    for (int i = 0; i < NP; i++) wrr_weight[i*WW +: WW] = WW'($urandom_range(0, 3));
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < NP; i++) begin
        ready[i] = ($urandom_range(0, 9) < 8);
        if (pkt_cnt[i] == 0 && $urandom_range(0, 19) == 0) pkt_cnt[i] = $urandom_range(1, 3);
      end
      apply_prep();
      if ($urandom_range(0, 299) == 0) sp0_wrr1 = ~sp0_wrr1;
      if ($urandom_range(0, 499) == 0)
        for (int i = 0; i < NP; i++) wrr_weight[i*WW +: WW] = WW'($urandom_range(0, 3));
      rst = ($urandom_range(0, 999) == 0);
    end
    rst = 1'b0;
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
